// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor.
// STAGES carry-propagating slices of CHUNK = WIDTH/STAGES bits. Slice k
// resolves chunk k of the result one enabled cycle after slice k-1. Stage k
// carries forward:
//   - the full operand words, so later slices pick up their chunks skewed by
//     k registers;
//   - the partially built sum, so every chunk stays aligned with the last one;
//   - the inter-slice carry;
//   - the valid bit.
// The last stage register is the output register. ovf and zero are resolved
// alongside it, so all outputs change on the same edge.
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             valid_out,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;

    // Stage registers: index k holds what slice k produced.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             ovf_q;
    logic             zero_q;

    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             c_d [STAGES];
    logic             v_d [STAGES];
    logic             ovf_d;
    logic             zero_d;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic             v_in;
        logic [CHUNK:0]   part;

        if (k == 0) begin : g_head
            // Subtraction is folded in up front as A + ~B + ~borrow, so the
            // slices only ever add; the inverted B carries the mode downstream.
            assign a_in = a;
            assign b_in = sub ? ~b : b;
            assign c_in = sub ^ cin;
            assign s_in = '0;
            assign v_in = valid_in;
        end else begin : g_body
            assign a_in = a_q[k-1];
            assign b_in = b_q[k-1];
            assign c_in = c_q[k-1];
            assign s_in = s_q[k-1];
            assign v_in = v_q[k-1];
        end

        assign part = {1'b0, a_in[k*CHUNK +: CHUNK]}
                    + {1'b0, b_in[k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, c_in};

        assign a_d[k] = a_in;
        assign b_d[k] = b_in;
        assign c_d[k] = part[CHUNK];
        assign v_d[k] = v_in;
        // Chunks above k are still zero in s_in, so OR-ing places chunk k.
        assign s_d[k] = s_in | (WIDTH'(part[CHUNK-1:0]) << (k * CHUNK));

        if (k == STAGES - 1) begin : g_tail
            // Carry into the MSB is recovered from the MSB sum bit and its inputs.
            assign ovf_d  = part[CHUNK] ^ (a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ part[CHUNK-1]);
            assign zero_d = (s_d[k] == '0);
        end
    end

    // Advance every stage together on enable; reset clears the whole pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
                v_q[k] <= v_d[k];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign valid_out = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: doc/pipelined_add_sub.md
# pipelined_add_sub

Parametrised, pipelined two's-complement adder/subtractor for the 32-bit RISC datapath. It is built as a chain of STAGES carry-propagating slices, and each slice adds WIDTH/STAGES bits per cycle. Registered carries and operand skew buffers let it accept a new operation every enabled cycle. It replaces per-bit full-adder chains in the ALU and address paths. It provides carry, signed-overflow and zero flags, plus a stall input for hazard holds.

## Interface
- WIDTH, 32: operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4: number of pipeline slices. Each slice is CHUNK = WIDTH/STAGES bits wide. STAGES = 1 gives a single registered adder.
- clk  input  1  rising-edge clock, sole clock of the block.
- rst  input  1  synchronous, active-high reset.
- en  input  1  pipeline advance. 0 freezes every internal register and every output.
- valid_in  input  1  operands and mode on this cycle are a real operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 selects A + B + cin; 1 selects A - B - cin (cin is treated as borrow-in).
- cin  input  1  carry-in (add) or borrow-in (sub), used to chain multi-word arithmetic.
- valid_out  output  1  result outputs hold a completed operation.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  raw carry out of the MSB. In sub mode, 1 means no borrow.
- ovf  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.
- zero  output  1  sum == 0.

## Operation
- Input conditioning, sampled when en=1:
  - b_eff = sub ? ~b : b
  - c0 = sub ? ~cin : cin
  - A - B - borrow therefore equals A + ~B + (1 - borrow).
- Slice k (0..STAGES-1) adds a[k*CHUNK +: CHUNK] + b_eff chunk + carry from slice k-1. Slice 0 uses c0.
- Slice k's sum chunk and carry-out are registered in stage k.
- Operand skew:
  - Chunk k of a and b_eff travels through k register stages before slice k consumes it.
  - The sub bit travels with the operands.
- Result deskew: sum chunk k is delayed by STAGES-1-k further registers, so all chunks of an operation reach the sum output together.
- Flags:
  - ovf and cout are computed in the last slice.
  - zero is computed combinationally from the aligned sum and registered together with it.
  - All flags update on the same edge as sum.
- valid_in travels down a STAGES-deep valid shift register, in lockstep with the data.
- When valid_in=0, the data registers still load (don't-care contents), but valid_out stays 0 for that slot.
- When en=0, nothing moves. The outputs keep their values, including valid_out=1 if it was set. Holding creates no duplicate and loses no operation.
- There is no back-pressure beyond en. The consumer must sample on cycles where en=1 and valid_out=1.

## Timing
- Latency is exactly STAGES enabled cycles, from the clk edge that samples valid_in=1 to the edge after which valid_out=1 with that operation's result.
- Throughput is one operation per enabled cycle. Back-to-back operations with different sub values do not interfere.
- Disabled cycles stretch latency one-for-one. For example, with STAGES=4 and one en=0 cycle in flight, the result appears after 5 edges.
- Reset, on the edge with rst=1:
  - Every pipeline register clears.
  - Outputs become valid_out=0, sum=0, cout=0, ovf=0, zero=0.
  - In-flight operations are discarded.
  - rst overrides en.
- Reset mid-stream: operations sampled on or before the reset edge never appear. An operation sampled on the first edge after reset appears STAGES cycles later.
- Wrap-around: sum wraps modulo 2^WIDTH and cout reports the lost carry. No saturation.
- STAGES=1: latency is 1 cycle and there are no skew registers.

## Test plan
- Reset and fill:
  - Assert rst for 2 cycles with valid_in=1. Then a=5, b=3, sub=0, cin=0, en=1.
  - Required: valid_out=0 during reset and for 3 cycles after it.
  - On the 4th edge: sum=8, cout=0, ovf=0, zero=0, valid_out=1.
- Carry chain across all slices:
  - a=32'hFFFF_FFFF, b=1, sub=0, cin=0.
  - Required: sum=0, cout=1, zero=1, ovf=0.
  - Then a=32'h7FFF_FFFF, b=1, which must give sum=32'h8000_0000, ovf=1, cout=0.
- Subtract and borrow:
  - a=3, b=5, sub=1, cin=0 must give sum=32'hFFFF_FFFE, cout=0, ovf=0.
  - a=10, b=4, sub=1, cin=1 must give sum=5, cout=1.
  - a=32'h8000_0000, b=1, sub=1, cin=0 must give ovf=1.
- Back-to-back stream:
  - Issue 4 consecutive operations alternating add and sub: (1+2), (9-4), (0+0), (6-7).
  - Required: results 3, 5, 0 (zero=1), 32'hFFFF_FFFF appear on 4 consecutive cycles starting at latency 4.
- Stall:
  - Issue 2 operations, then drop en for 3 cycles mid-flight.
  - Required: outputs frozen during the stall, valid_out does not toggle, and both results appear in order exactly 3 cycles late.
  - Then assert rst while 2 operations are in flight. Required: neither result ever appears.
- Parameter sweep: repeat 200 random operations for (WIDTH, STAGES) = (32,1), (32,4), (32,8), (16,2), checking against a behavioural a ± b ± cin reference model with the expected latency.
